// File: rtl/enc_stage_2_if.sv
// Handshake bundle for enc_stage_2: stage-1 codeword input, extended codeword output,
// error pulse and delivered-word counter.
interface enc_stage_2_if #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int CNT_WIDTH          = 16
);
    logic [MAX_CODEWORD_WIDTH-1:0] data_in;
    logic [1:0]                    mod;
    logic                          in_valid;
    logic                          in_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] data_out;
    logic [1:0]                    out_mod;
    logic                          out_valid;
    logic                          out_ready;
    logic                          err_mod;
    logic [CNT_WIDTH-1:0]          word_cnt;

    modport master (
        output data_in, mod, in_valid, out_ready,
        input  in_ready, data_out, out_mod, out_valid, err_mod, word_cnt
    );

    modport slave (
        input  data_in, mod, in_valid, out_ready,
        output in_ready, data_out, out_mod, out_valid, err_mod, word_cnt
    );
endinterface

// File: rtl/enc_stage_2.sv
// Second encoder stage: appends the overall parity bit to an N-bit codeword
// (N = 8/16/32 by mode) and buffers results in a 2-entry FIFO.
module enc_stage_2 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic         clk,
    input  logic         rst,
    enc_stage_2_if.slave bus
);
    localparam int W = MAX_CODEWORD_WIDTH;

    // Keeps bits [N-2:0], places their XOR at bit N-1, zeroes everything above.
    function automatic logic [W-1:0] extend_word(input logic [W-1:0] d, input logic [1:0] m);
        int          n;
        logic        p;
        logic [W-1:0] r;
        n = 8 << m;
        p = 1'b0;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (i < n - 1) begin
                r[i] = d[i];
                p    = p ^ d[i];
            end
        end
        for (int i = 0; i < W; i++) begin
            if (i == n - 1) r[i] = p;
        end
        return r;
    endfunction

    logic [W-1:0]         ext_p0;
    logic                 legal_p0;
    logic                 accept;
    logic                 push;
    logic                 pop;

    logic [W-1:0]         data_mem [2];
    logic [1:0]           mod_mem  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           occ;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign ext_p0   = extend_word(bus.data_in, bus.mod);
    assign legal_p0 = (bus.mod != 2'd3);

    // in_ready depends on registered occupancy only, never on out_ready or in_valid.
    assign bus.in_ready  = (occ < 2'd2);
    assign bus.out_valid = (occ != 2'd0);

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal_p0;
    assign pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                cnt_q  <= cnt_q + CNT_WIDTH'(1);
            end
            err_q <= accept && !legal_p0;
        end
    end

    // Storage carries no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= ext_p0;
            mod_mem[wr_ptr]  <= bus.mod;
        end
    end

    assign bus.data_out = bus.out_valid ? data_mem[rd_ptr] : '0;
    assign bus.out_mod  = bus.out_valid ? mod_mem[rd_ptr]  : 2'd0;
    assign bus.err_mod  = err_q;
    assign bus.word_cnt = cnt_q;
endmodule

// File: tb/tb_enc_stage_2.sv
// Bench for enc_stage_2: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed results; a CNT_WIDTH=4 copy checks wrap.
module tb_enc_stage_2;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    enc_stage_2_if #(.MAX_CODEWORD_WIDTH(32), .CNT_WIDTH(16)) b ();
    enc_stage_2_if #(.MAX_CODEWORD_WIDTH(32), .CNT_WIDTH(4))  bs ();

    enc_stage_2 #(.MAX_CODEWORD_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst_n), .bus(b)
    );
    enc_stage_2 #(.MAX_CODEWORD_WIDTH(32), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst_n), .bus(bs)
    );

    assign bs.data_in   = b.data_in;
    assign bs.mod       = b.mod;
    assign bs.in_valid  = b.in_valid;
    assign bs.out_ready = b.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: N = 8 << mod, keep low N-1 bits, parity = odd popcount at bit N-1.
    function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [1:0] m);
        int          n;
        logic [63:0] mask;
        logic [63:0] v;
        int          ones;
        n    = 8 << m;
        mask = (64'd1 << (n - 1)) - 64'd1;
        v    = {32'd0, d} & mask;
        ones = $countones(v);
        v    = v | (64'(ones % 2) << (n - 1));
        return v[31:0];
    endfunction

    logic [31:0] mq_data[$];
    logic [1:0]  mq_mod[$];
    logic        m_err;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_data.delete();
            mq_mod.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            automatic bit room = (mq_data.size() < 2);
            automatic bit take = b.in_valid && room;
            automatic bit give = b.out_ready && (mq_data.size() > 0);
            m_err = take && (b.mod == 2'd3);
            if (give) begin
                void'(mq_data.pop_front());
                void'(mq_mod.pop_front());
                m_cnt++;
            end
            if (take && b.mod != 2'd3) begin
                mq_data.push_back(model_ext(b.data_in, b.mod));
                mq_mod.push_back(b.mod);
            end
        end
    end

    always @(negedge clk) begin
        automatic bit has = (mq_data.size() > 0);
        chk("out_valid", 64'(b.out_valid), 64'(has));
        chk("data_out", 64'(b.data_out), has ? 64'(mq_data[0]) : 64'd0);
        chk("out_mod", 64'(b.out_mod), has ? 64'(mq_mod[0]) : 64'd0);
        chk("in_ready", 64'(b.in_ready), 64'(mq_data.size() < 2));
        chk("err_mod", 64'(b.err_mod), 64'(m_err));
        chk("word_cnt", 64'(b.word_cnt), 64'(m_cnt & 16'hFFFF));
        chk("word_cnt_small", 64'(bs.word_cnt), 64'(m_cnt & 4'hF));
        chk("data_out_small", 64'(bs.data_out), 64'(b.data_out));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word and waits (bounded) until it is taken; leaves in_valid high.
    task automatic push(input logic [31:0] d, input logic [1:0] m);
        bit ok;
        b.in_valid = 1'b1;
        b.data_in  = d;
        b.mod      = m;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = b.in_ready;
            tick();
        end
        chk("push_accepted", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b.in_valid  = 1'b0;
        b.data_in   = '0;
        b.mod       = 2'd0;
        b.out_ready = 1'b0;

        chk("model_mod0", 64'(model_ext(32'h0000_000B, 2'd0)), 64'h8B);
        chk("model_mod1", 64'(model_ext(32'hFFFF_7FFF, 2'd1)), 64'hFFFF);
        chk("model_mod2", 64'(model_ext(32'h8000_0001, 2'd2)), 64'h8000_0001);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(b.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b.out_valid), 64'd0);
        chk("rst_word_cnt", 64'(b.word_cnt), 64'd0);
        chk("rst_err_mod", 64'(b.err_mod), 64'd0);

        b.out_ready = 1'b1;
        push(32'h0000_000B, 2'd0);
        b.in_valid = 1'b0;
        chk("m0_data", 64'(b.data_out), 64'h8B);
        chk("m0_mod", 64'(b.out_mod), 64'd0);
        tick();
        chk("m0_cnt", 64'(b.word_cnt), 64'd1);
        chk("m0_drained", 64'(b.out_valid), 64'd0);

        push(32'hFFFF_7FFF, 2'd1);
        chk("m1_data", 64'(b.data_out), 64'hFFFF);
        chk("m1_mod", 64'(b.out_mod), 64'd1);
        push(32'h0000_0003, 2'd2);
        b.in_valid = 1'b0;
        chk("m2_data", 64'(b.data_out), 64'h3);
        chk("m2_mod", 64'(b.out_mod), 64'd2);
        tick();
        chk("m2_cnt", 64'(b.word_cnt), 64'd3);

        b.out_ready = 1'b0;
        push(32'h0000_00AA, 2'd0);
        chk("bp_first", 64'(b.data_out), 64'hAA);
        push(32'h1234_5678, 2'd1);
        chk("bp_full", 64'(b.in_ready), 64'd0);
        b.data_in = 32'h8000_0001;
        b.mod     = 2'd2;
        tick();
        chk("bp_held_ready", 64'(b.in_ready), 64'd0);
        chk("bp_held_data", 64'(b.data_out), 64'hAA);
        tick();
        chk("bp_stable", 64'(b.data_out), 64'hAA);
        b.out_ready = 1'b1;
        tick();
        chk("bp_second", 64'(b.data_out), 64'h5678);
        chk("bp_second_mod", 64'(b.out_mod), 64'd1);
        chk("bp_slot_free", 64'(b.in_ready), 64'd1);
        tick();
        b.in_valid = 1'b0;
        chk("bp_third", 64'(b.data_out), 64'h8000_0001);
        chk("bp_third_mod", 64'(b.out_mod), 64'd2);
        tick();
        chk("bp_cnt", 64'(b.word_cnt), 64'd6);
        chk("bp_empty", 64'(b.out_valid), 64'd0);

        chk("ill_ready", 64'(b.in_ready), 64'd1);
        b.in_valid = 1'b1;
        b.data_in  = 32'h0000_00FF;
        b.mod      = 2'd3;
        tick();
        b.in_valid = 1'b0;
        chk("ill_err", 64'(b.err_mod), 64'd1);
        chk("ill_no_out", 64'(b.out_valid), 64'd0);
        tick();
        chk("ill_err_clear", 64'(b.err_mod), 64'd0);
        chk("ill_cnt", 64'(b.word_cnt), 64'd6);

        b.out_ready = 1'b0;
        push(32'h0000_0055, 2'd0);
        b.mod       = 2'd3;
        b.out_ready = 1'b1;
        tick();
        b.in_valid = 1'b0;
        chk("ill_del_err", 64'(b.err_mod), 64'd1);
        chk("ill_del_empty", 64'(b.out_valid), 64'd0);
        chk("ill_del_cnt", 64'(b.word_cnt), 64'd7);

        for (int c = 0; c < 300; c++) begin
            b.in_valid  = 1'($urandom_range(0, 1));
            b.mod       = 2'($urandom_range(0, 3));
            b.data_in   = $urandom;
            b.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        b.in_valid = 1'b0;

        b.out_ready = 1'b0;
        push(32'h0000_0011, 2'd0);
        push(32'h0000_0022, 2'd0);
        b.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(b.out_valid), 64'd0);
        chk("arst_data", 64'(b.data_out), 64'd0);
        chk("arst_ready", 64'(b.in_ready), 64'd1);
        chk("arst_cnt", 64'(b.word_cnt), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        b.out_ready = 1'b1;
        repeat (3) tick();
        chk("arst_no_word", 64'(b.out_valid), 64'd0);
        chk("arst_cnt_after", 64'(b.word_cnt), 64'd0);

        for (int w = 0; w < 16; w++) push($urandom, 2'($urandom_range(0, 2)));
        b.in_valid = 1'b0;
        repeat (2) tick();
        chk("wrap_small", 64'(bs.word_cnt), 64'd0);
        chk("wrap_big", 64'(b.word_cnt), 64'd16);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_stage_2.md
ENC_STAGE_2 -- requirements
Module: enc_stage_2

Interface
REQ-001 Parameter: MAX_CODEWORD_WIDTH, default 32, widest codeword supported; mod 0/1/2 codeword lengths N = 8/16/32.
REQ-002 Parameter: CNT_WIDTH, default 16, width of delivered-word counter.
REQ-003 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: data_in  in  MAX_CODEWORD_WIDTH  stage-1 codeword; bits [N-2:0] hold info+parity, bit N-1 and above don't-care.
REQ-006 Port: mod  in  2  code mode qualifying data_in; 3 illegal.
REQ-007 Port: in_valid  in  1  upstream word present.
REQ-008 Port: in_ready  out  1  block can accept a word this cycle.
REQ-009 Port: data_out  out  MAX_CODEWORD_WIDTH  completed extended codeword.
REQ-010 Port: out_mod  out  2  mode of word on data_out.
REQ-011 Port: out_valid  out  1  data_out/out_mod valid.
REQ-012 Port: out_ready  in  1  downstream accepts word.
REQ-013 Port: err_mod  out  1  one-cycle pulse: illegal mode word dropped.
REQ-014 Port: word_cnt  out  CNT_WIDTH  count of words delivered downstream.

Function
REQ-015 Input handshake completes when in_valid && in_ready on a rising edge; output handshake when out_valid && out_ready.
REQ-016 Storage is a 2-entry FIFO (data, mod); in_ready SHALL be 1 iff occupancy < 2, derived from registered state only (no combinational path from out_ready or in_valid).
REQ-017 On accept with mod in {0,1,2}: stored word = bits [N-2:0] of data_in, bit N-1 = XOR of data_in[N-2:0], bits [MAX_CODEWORD_WIDTH-1:N] = 0.
REQ-018 On accept with mod = 3: word not stored, occupancy unchanged, err_mod = 1 in the following cycle only.
REQ-019 Latency: word accepted at edge t appears on data_out with out_valid = 1 after edge t (visible cycle t+1) when FIFO was empty; otherwise after all older words drain, in order.
REQ-020 out_valid = 1 iff occupancy > 0; data_out/out_mod driven from FIFO head, held stable while out_valid && !out_ready.
REQ-021 Simultaneous accept and deliver at occupancy 1: occupancy stays 1, new word becomes head next cycle; at occupancy 2 no accept possible (in_ready = 0), deliver frees one slot, in_ready = 1 next cycle.
REQ-022 Simultaneous illegal-mode accept and deliver: deliver proceeds, occupancy decrements, err_mod pulses.
REQ-023 When out_valid = 0, data_out and out_mod SHALL be 0.
REQ-024 word_cnt increments by 1 per output handshake, wraps all-ones -> 0; not incremented for dropped words.
REQ-025 FIFO pointers wrap modulo 2; no overflow or underflow reachable through legal handshakes.

Reset
REQ-026 rst low asynchronously clears: occupancy 0, pointers 0, data_out 0, out_mod 0, out_valid 0, err_mod 0, word_cnt 0; in_ready = 1 from first edge after rst deasserts.
REQ-027 rst asserted mid-operation discards all buffered words; no partial word delivered after release.

Verification
REQ-028 mod=0, data_in=32'h0000_000B, out_ready=1 -> next cycle data_out=32'h0000_008B, out_mod=0, word_cnt=1.
REQ-029 mod=1, data_in=32'hFFFF_7FFF -> data_out=32'h0000_FFFF (upper bits masked, parity 1); mod=2, data_in=32'h0000_0003 -> data_out=32'h0000_0003.
REQ-030 out_ready=0, three back-to-back valid words -> in_ready=0 after second accept, third held upstream, data_out stable at first word; release out_ready -> words delivered in order, word_cnt=3.
REQ-031 mod=3, in_valid=1 on empty FIFO -> in_ready=1, err_mod=1 for exactly one cycle, out_valid stays 0, word_cnt unchanged.
REQ-032 Two words buffered, rst pulsed low between edges -> outputs 0 immediately, after release no word delivered, word_cnt=0.
REQ-033 Counter wrap: preload by delivering 2^CNT_WIDTH words (reduced CNT_WIDTH=4, 16 words) -> word_cnt returns to 0.
